// File: rtl/fetch_stage.sv
// Instruction fetch: PC, credit-limited imem requests, {instr,pc} buffer; id_valid earliest one cycle after a response.
// Requests stall while in-flight + buffered would exceed BUF_DEPTH; responses are never back-pressured.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
);
    localparam int CW = $clog2(BUF_DEPTH + 1) + 1;
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    typedef enum logic {ST_FETCH, ST_FLUSH} state_t;

    state_t          r_state, w_state_nxt;
    logic [31:0]     r_pc, r_resp_pc;
    logic [CW-1:0]   r_out_cnt, r_drop_cnt, r_count;
    logic [PW-1:0]   r_rd_ptr, r_wr_ptr;
    logic [31:0]     r_instr_mem [BUF_DEPTH];
    logic [31:0]     r_pc_mem    [BUF_DEPTH];

    logic            w_pop, w_acc, w_push, w_credit_ok;
    logic [CW-1:0]   w_pop_c, w_acc_c, w_push_c, w_resp_c, w_used;
    logic [CW-1:0]   w_drop_redir, w_drop_nxt;
    logic [31:0]     w_redirect_aligned;

    assign id_valid  = (r_count != '0);
    assign id_instr  = id_valid ? r_instr_mem[r_rd_ptr] : '0;
    assign id_pc     = id_valid ? r_pc_mem[r_rd_ptr]    : '0;
    assign w_pop     = id_valid && id_ready;

    // Credit counts the slot freed by this cycle's pop so k=1 streams at full rate.
    assign w_pop_c     = {{(CW-1){1'b0}}, w_pop};
    assign w_used      = r_out_cnt + r_count - w_pop_c;
    assign w_credit_ok = (w_used < CW'(BUF_DEPTH));

    assign imem_req_valid = (r_state == ST_FETCH) && !rst && !redirect_valid && w_credit_ok;
    assign imem_req_addr  = r_pc;
    assign w_acc          = imem_req_valid && imem_req_ready;
    assign w_push         = imem_resp_valid && (r_state == ST_FETCH) && !redirect_valid;

    assign w_acc_c   = {{(CW-1){1'b0}}, w_acc};
    assign w_push_c  = {{(CW-1){1'b0}}, w_push};
    assign w_resp_c  = {{(CW-1){1'b0}}, imem_resp_valid};
    assign w_drop_redir       = r_drop_cnt + r_out_cnt + w_acc_c - w_resp_c;
    assign w_redirect_aligned = redirect_pc & ~32'h3;

    always_comb begin
        w_drop_nxt  = r_drop_cnt;
        w_state_nxt = r_state;
        if (redirect_valid) begin
            w_drop_nxt  = w_drop_redir;
            w_state_nxt = (w_drop_redir != '0) ? ST_FLUSH : ST_FETCH;
        end else if (r_state == ST_FLUSH && imem_resp_valid) begin
            w_drop_nxt = r_drop_cnt - 1'b1;
            if (r_drop_cnt == CW'(1)) begin
                w_state_nxt = ST_FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC & ~32'h3;
            r_resp_pc  <= RESET_PC & ~32'h3;
            r_out_cnt  <= '0;
            r_drop_cnt <= '0;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else if (redirect_valid) begin
            r_pc       <= w_redirect_aligned;
            r_resp_pc  <= w_redirect_aligned;
            r_out_cnt  <= '0;
            r_drop_cnt <= w_drop_nxt;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else begin
            if (w_acc) begin
                r_pc <= r_pc + 32'd4;
            end
            r_out_cnt  <= r_out_cnt + w_acc_c - w_push_c;
            r_drop_cnt <= w_drop_nxt;
            r_count    <= r_count + w_push_c - w_pop_c;
            if (w_push) begin
                r_resp_pc <= r_resp_pc + 32'd4;
                r_wr_ptr  <= (r_wr_ptr == PW'(BUF_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PW'(BUF_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: id_* are gated by occupancy.
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_instr_mem[r_wr_ptr] <= imem_resp_data;
            r_pc_mem[r_wr_ptr]    <= r_resp_pc;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: two instances (RESET_PC 0 and FFFF_FFF8) with behavioural instruction memories.
module tb_fetch_stage;
    logic        clk;
    logic        rst;
    logic        req_v, req_rdy, rsp_v, redir, id_v, id_rdy;
    logic [31:0] req_addr, rsp_d, redir_pc, id_instr, id_pc;
    logic        req_v1, rsp_v1, id_v1;
    logic [31:0] addr1, rsp_d1, instr1, pc1;
    int          lat;
    int          n_vec = 0;
    int          n_err = 0;

    fetch_stage #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) u0 (
        .clk(clk), .rst(rst),
        .imem_req_valid(req_v), .imem_req_ready(req_rdy), .imem_req_addr(req_addr),
        .imem_resp_valid(rsp_v), .imem_resp_data(rsp_d),
        .redirect_valid(redir), .redirect_pc(redir_pc),
        .id_valid(id_v), .id_ready(id_rdy), .id_instr(id_instr), .id_pc(id_pc)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) u1 (
        .clk(clk), .rst(rst),
        .imem_req_valid(req_v1), .imem_req_ready(1'b1), .imem_req_addr(addr1),
        .imem_resp_valid(rsp_v1), .imem_resp_data(rsp_d1),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .id_valid(id_v1), .id_ready(1'b1), .id_instr(instr1), .id_pc(pc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory for u0: fixed latency lat (1..3), instruction word = ~address.
    logic [2:0]  mv;
    logic [31:0] md [3];
    assign rsp_v = mv[0];
    assign rsp_d = md[0];
    always @(posedge clk) begin
        if (rst) begin
            mv <= '0;
        end else begin
            mv[0] <= mv[1]; md[0] <= md[1];
            mv[1] <= mv[2]; md[1] <= md[2];
            mv[2] <= 1'b0;
            if (req_v && req_rdy) begin
                mv[lat-1] <= 1'b1;
                md[lat-1] <= ~req_addr;
            end
        end
    end

    // Memory for u1: always ready, latency 1.
    always @(posedge clk) begin
        if (rst) rsp_v1 <= 1'b0;
        else     rsp_v1 <= req_v1;
        rsp_d1 <= ~addr1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_id(input string tag, input logic [31:0] pc);
        chk({tag, "_vld"},   32'(id_v), 32'd1);
        chk({tag, "_pc"},    id_pc, pc);
        chk({tag, "_instr"}, id_instr, ~pc);
    endtask

    task automatic chk_req(input string tag, input logic [31:0] addr);
        chk({tag, "_rvld"},  32'(req_v), 32'd1);
        chk({tag, "_raddr"}, req_addr, addr);
    endtask

    task automatic nxt;
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [31:0] e;
        rst = 1'b1; req_rdy = 1'b1; id_rdy = 1'b1; redir = 1'b0; redir_pc = '0; lat = 1;
        // Reset values and wrap at FFFF_FFF8
        nxt();
        #1;
        chk("rst_rvld",  32'(req_v), 32'd0);
        chk("rst_idvld", 32'(id_v), 32'd0);
        chk("rst_instr", id_instr, 32'd0);
        chk("rst_idpc",  id_pc, 32'd0);
        chk("rst_addr",  req_addr, 32'd0);
        chk("rst_addr1", addr1, 32'hFFFF_FFF8);
        chk("rst_rvld1", 32'(req_v1), 32'd0);
        rst = 1'b0;
        #1;
        chk_req("s_c1", 32'h0);
        chk("s_c1_addr1", addr1, 32'hFFFF_FFF8);
        nxt(); #1;
        chk_req("s_c2", 32'h4);
        chk("s_c2_idvld", 32'(id_v), 32'd0);
        chk("s_c2_addr1", addr1, 32'hFFFF_FFFC);
        nxt();
        for (int c = 3; c <= 6; c++) begin
            #1;
            chk_id("s_id", 32'(4 * (c - 3)));
            chk_req("s_req", 32'(4 * (c - 1)));
            e = 32'hFFFF_FFF8 + 32'(4 * (c - 3));
            chk("w_idvld", 32'(id_v1), 32'd1);
            chk("w_idpc", pc1, e);
            chk("w_instr", instr1, ~e);
            chk("w_addr", addr1, 32'hFFFF_FFF8 + 32'(4 * (c - 1)));
            nxt();
        end

        // Decode stalled: buffer fills, then drains in order
        rst = 1'b1; #1; nxt();
        rst = 1'b0; id_rdy = 1'b0;
        #1; chk_req("b_c1", 32'h0); nxt();
        #1; chk_req("b_c2", 32'h4); nxt();
        #1; chk("b_c3_rvld", 32'(req_v), 32'd0); chk_id("b_c3", 32'h0); nxt();
        #1; chk("b_c4_rvld", 32'(req_v), 32'd0); chk_id("b_c4", 32'h0); nxt();
        id_rdy = 1'b1;
        #1; chk_req("b_c5", 32'h8); chk_id("b_c5", 32'h0); nxt();
        #1; chk_req("b_c6", 32'hC); chk_id("b_c6", 32'h4); nxt();
        #1; chk_id("b_c7", 32'h8); nxt();

        // k=3, two in flight, redirect (unaligned target) squashes both
        rst = 1'b1; lat = 3; #1; nxt();
        rst = 1'b0;
        #1; chk_req("f_c1", 32'h0); nxt();
        #1; chk_req("f_c2", 32'h4); nxt();
        redir = 1'b1; redir_pc = 32'h103;
        #1; chk("f_c3_rvld", 32'(req_v), 32'd0); nxt();
        redir = 1'b0;
        #1; chk("f_c4_rvld", 32'(req_v), 32'd0); chk("f_c4_idvld", 32'(id_v), 32'd0); nxt();
        #1; chk("f_c5_rvld", 32'(req_v), 32'd0); chk("f_c5_idvld", 32'(id_v), 32'd0); nxt();
        #1; chk_req("f_c6", 32'h100); chk("f_c6_idvld", 32'(id_v), 32'd0); nxt();
        #1; chk_req("f_c7", 32'h104); chk("f_c7_idvld", 32'(id_v), 32'd0); nxt();
        #1; chk("f_c8_rvld", 32'(req_v), 32'd0); nxt();
        #1; chk("f_c9_idvld", 32'(id_v), 32'd0); nxt();
        #1; chk_id("f_c10", 32'h100); chk_req("f_c10", 32'h108); nxt();

        // Redirect coinciding with a response and a pop
        rst = 1'b1; lat = 1; #1; nxt();
        rst = 1'b0;
        #1; chk_req("r_c1", 32'h0); nxt();
        #1; chk_req("r_c2", 32'h4); nxt();
        redir = 1'b1; redir_pc = 32'h200;
        #1; chk_id("r_c3", 32'h0); chk("r_c3_rvld", 32'(req_v), 32'd0); nxt();
        redir = 1'b0;
        #1; chk("r_c4_idvld", 32'(id_v), 32'd0); chk_req("r_c4", 32'h200); nxt();
        #1; chk("r_c5_idvld", 32'(id_v), 32'd0); nxt();
        #1; chk_id("r_c6", 32'h200); nxt();
        #1; chk_id("r_c7", 32'h204); nxt();

        // Reset while flushing two squashed requests
        rst = 1'b1; lat = 3; #1; nxt();
        rst = 1'b0;
        nxt();
        nxt();
        redir = 1'b1; redir_pc = 32'h300;
        nxt();
        redir = 1'b0; rst = 1'b1; lat = 1;
        #1; chk("x_c4_rvld", 32'(req_v), 32'd0); nxt();
        rst = 1'b0;
        #1;
        chk("x_c5_idvld", 32'(id_v), 32'd0);
        chk("x_c5_instr", id_instr, 32'd0);
        chk("x_c5_idpc", id_pc, 32'd0);
        chk_req("x_c5", 32'h0);
        nxt();
        #1; chk_req("x_c6", 32'h4); nxt();
        #1; chk_id("x_c7", 32'h0); nxt();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
